spi_piso_master: RTL and testbench

SPI_PISO_MASTER -- requirements
Module: spi_piso_master

---
 rtl/spi_piso_master.sv | 106 ++++++++++
 tb/tb_spi_piso_master.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_piso_master.sv
// spi_piso_master: parallel-in serial-out SPI master, LSB first, runtime CPOL/CPHA
module spi_piso_master #(
    parameter int D_Pack = 8,
    parameter int DIV = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [D_Pack-1:0] DATA_IN,
    input  logic              START,
    input  logic              C_PH,
    input  logic              C_POL,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_N,
    output logic              BUSY,
    output logic              DONE
);
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
    localparam int KW = $clog2(2 * D_Pack);
    localparam logic [KW-1:0] K_LAST = KW'(2 * D_Pack - 1);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d, k_nx;
    logic [D_Pack-1:0] sh_q, sh_d;
    logic pol_q, pol_d, pha_q, pha_d, sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, done_q, done_d;
    logic wrap;
    assign wrap = cnt_q == 8'(DIV - 1);
    assign k_nx = state_q == LEAD ? '0 : k_q + KW'(1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            sh_q    <= '0;
            pol_q   <= 1'b0;
            pha_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            pol_q   <= pol_d;
            pha_q   <= pha_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || wrap) ? 8'd0 : cnt_q + 8'd1;
        k_d     = k_q;
        sh_d    = sh_q;
        pol_d   = pol_q;
        pha_d   = pha_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = C_POL;
                if (START) begin
                    state_d = LEAD;
                    pol_d   = C_POL;
                    pha_d   = C_PH;
                    sh_d    = C_PH ? DATA_IN : DATA_IN >> 1;
                    mosi_d  = ~C_PH & DATA_IN[0];
                    cs_n_d  = 1'b0;
                end
            end
            LEAD, SHIFT: if (wrap) begin
                if (state_q == SHIFT && k_q == K_LAST) begin
                    state_d = TRAIL;
                    sclk_d  = pol_q;
                end else begin
                    state_d = SHIFT;
                    k_d     = k_nx;
                    sclk_d  = pol_q ^ ~k_nx[0];
                    // new bit on odd halves (CPHA=0) or even halves (CPHA=1); last half only holds
                    if (k_nx[0] != pha_q && k_nx != K_LAST) begin
                        mosi_d = sh_q[0];
                        sh_d   = sh_q >> 1;
                    end
                end
            end
            TRAIL: if (wrap) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign CS_N = cs_n_q;
    assign BUSY = state_q != IDLE;
    assign DONE = done_q;
endmodule

// File: tb/tb_spi_piso_master.sv
// tb_spi_piso_master: directed + random transfers on an 8-bit/DIV=2 and a 16-bit/DIV=1 instance
module tb_spi_piso_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data_a = '0;
    logic [15:0] data_b = '0;
    logic start_a = 1'b0, start_b = 1'b0, pol_a = 1'b0, pol_b = 1'b0, pha_a = 1'b0, pha_b = 1'b0;
    logic sclk_a, mosi_a, csn_a, busy_a, done_a;
    logic sclk_b, mosi_b, csn_b, busy_b, done_b;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    spi_piso_master #(.D_Pack(8), .DIV(2)) u_a (
        .CLK(clk), .RST(rst), .DATA_IN(data_a), .START(start_a), .C_PH(pha_a), .C_POL(pol_a),
        .SCLK(sclk_a), .MOSI(mosi_a), .CS_N(csn_a), .BUSY(busy_a), .DONE(done_a)
    );
    spi_piso_master #(.D_Pack(16), .DIV(1)) u_b (
        .CLK(clk), .RST(rst), .DATA_IN(data_b), .START(start_b), .C_PH(pha_b), .C_POL(pol_b),
        .SCLK(sclk_b), .MOSI(mosi_b), .CS_N(csn_b), .BUSY(busy_b), .DONE(done_b)
    );
    function automatic logic [4:0] obs(input bit sel);
        return sel ? {sclk_b, mosi_b, csn_b, busy_b, done_b} : {sclk_a, mosi_a, csn_a, busy_a, done_a};
    endfunction
    // expected {sclk, mosi, cs_n, busy, done} in cycle t after the accepting edge
    function automatic logic [4:0] exp_out(input int t, input logic [31:0] d, input logic pol,
                                           input logic pha, input int dw, input int dv);
        int n, k, b;
        n = (2 * dw + 2) * dv;
        if (t == n) return {pol, 1'b0, 1'b1, 1'b0, 1'b1};
        if (t < dv) return {pol, pha ? 1'b0 : d[0], 1'b0, 1'b1, 1'b0};
        k = (t - dv) / dv;
        if (k >= 2 * dw) return {pol, d[dw-1], 1'b0, 1'b1, 1'b0};
        b = pha ? k / 2 : (k + 1) / 2;
        if (b > dw - 1) b = dw - 1;
        return {(k % 2 == 0) ? ~pol : pol, d[b], 1'b0, 1'b1, 1'b0};
    endfunction
    task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask
    task automatic drive(input bit sel, input logic st, input logic [31:0] d, input logic pol, input logic pha);
        if (sel) begin
            start_b = st; data_b = d[15:0]; pol_b = pol; pha_b = pha;
        end else begin
            start_a = st; data_a = d[7:0]; pol_a = pol; pha_a = pha;
        end
    endtask
    task automatic idle_chk(input bit sel, input int n);
        logic p;
        for (int i = 0; i < n; i++) begin
            p = 1'($urandom);
            drive(sel, 1'b0, 32'd0, p, 1'b0);
            @(negedge clk);
            chk("idle", obs(sel), {p, 1'b0, 1'b1, 1'b0, 1'b0});
        end
    endtask
    // called just after a negedge; returns at the negedge of the DONE cycle
    task automatic xfer(input bit sel, input logic [31:0] din, input logic pol, input logic pha, input bit keep);
        int dw, dv, n, ne;
        logic [31:0] d, rx;
        logic [4:0] o;
        logic ps;
        dw = sel ? 16 : 8;
        dv = sel ? 1 : 2;
        n = (2 * dw + 2) * dv;
        d = din & 32'((64'd1 << dw) - 64'd1);
        rx = '0;
        ne = 0;
        ps = pol;
        drive(sel, 1'b1, d, pol, pha);
        @(posedge clk);
        for (int t = 0; t <= n; t++) begin
            @(negedge clk);
            o = obs(sel);
            chk($sformatf("%s d=%h pol=%b pha=%b t=%0d", sel ? "b" : "a", d, pol, pha, t), o,
                exp_out(t, d, pol, pha, dw, dv));
            if (t < n && o[4] != ps && o[4] == (pha ? pol : ~pol) && ne < 32) begin
                rx[ne] = o[3];
                ne++;
            end
            ps = o[4];
            if (!keep && t == 0) drive(sel, 1'b0, d, pol, pha);
            if (!keep && t == 5) drive(sel, 1'b1, $urandom, 1'($urandom), 1'($urandom));
            if (!keep && t == 6) drive(sel, 1'b0, d, pol, pha);
        end
        tests++;
        assert (ne == dw) else begin
            fails++;
            $error("FAIL edges obs=%0d exp=%0d", ne, dw);
        end
        tests++;
        assert (rx === d) else begin
            fails++;
            $error("FAIL rxword obs=%h exp=%h", rx, d);
        end
    endtask
    initial begin
        logic p, h;
        start_a = 1'b1;
        pol_a = 1'b1;
        pol_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a", obs(0), 5'b00100);
        chk("rst_b", obs(1), 5'b00100);
        rst = 1'b0;
        xfer(0, 32'hA5, 1'b0, 1'b0, 1'b0);
        xfer(0, 32'h3C, 1'b1, 1'b1, 1'b0);
        idle_chk(0, 4);
        for (int i = 0; i < 6; i++) begin
            xfer(0, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            if (i % 2 == 1) idle_chk(0, 3);
        end
        for (int i = 0; i < 3; i++) xfer(0, $urandom, 1'b0, 1'b0, i < 2);
        idle_chk(0, 3);
        p = 1'($urandom);
        h = 1'($urandom);
        drive(0, 1'b1, 32'h96, p, h);
        @(posedge clk);
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            if (t == 0) drive(0, 1'b0, 32'h96, p, h);
        end
        chk("pre_rst", obs(0), exp_out(12, 32'h96, p, h, 8, 2));
        rst = 1'b1;
        drive(0, 1'b1, 32'hFF, p, h);
        @(negedge clk);
        chk("mid_rst", obs(0), 5'b00100);
        rst = 1'b0;
        xfer(0, 32'hFF, p, h, 1'b0);
        idle_chk(0, 2);
        xfer(1, 32'h8001, 1'b0, 1'b0, 1'b0);
        xfer(1, 32'h8001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) xfer(1, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        idle_chk(1, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
